wb_cmd_master: RTL and testbench

Wishbone classic single-cycle initiator that turns a simple valid/ready command stream (from a UART/SPI/LA front end) into one Wishbone read or write per command, and returns the read data or a timeout error on a valid/ready response stream. It is the bus-master counterpart to the project-select harness: it drives the harness `wbs_*` slave port for bring-up and test without the management core.

---
 rtl/wb_cmd_master_if.sv | 42 ++++
 rtl/wb_cmd_master.sv | 123 ++++++++++++
 tb/tb_wb_cmd_master.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_if.sv
// Command/response stream and Wishbone initiator bundle for wb_cmd_master.
// "master" is the view of the command master itself, "slave" the view of everything around it.
interface wb_cmd_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic [3:0]  cmd_sel;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_err;

   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
      output cmd_ready,
      output rsp_valid, rsp_dat, rsp_err,
      input  rsp_ready,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
      input  cmd_ready,
      input  rsp_valid, rsp_dat, rsp_err,
      output rsp_ready,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/wb_cmd_master.sv
// Turns a valid/ready command stream into single Wishbone classic transfers and
// returns read data, or ERR_DATA with rsp_err on timeout, on a valid/ready response stream.
module wb_cmd_master #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_ni,
   wb_cmd_master_if.master       bus,
   output logic [15:0]           xfer_count,
   output logic [7:0]            err_count
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [31:0] rsp_dat_q, rsp_dat_d;
   logic        rsp_err_q, rsp_err_d;
   logic [15:0] xfer_q, xfer_d;
   logic [7:0]  err_q, err_d;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         adr_q     <= 32'h0;
         dat_q     <= 32'h0;
         sel_q     <= 4'h0;
         tmo_q     <= 8'h0;
         rsp_dat_q <= 32'h0;
         rsp_err_q <= 1'b0;
         xfer_q    <= 16'h0;
         err_q     <= 8'h0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         sel_q     <= sel_d;
         tmo_q     <= tmo_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
         xfer_q    <= xfer_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      sel_d     = sel_q;
      tmo_d     = tmo_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;
      xfer_d    = xfer_q;
      err_d     = err_q;

      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               we_d    = bus.cmd_we;
               adr_d   = bus.cmd_adr;
               dat_d   = bus.cmd_dat;
               sel_d   = bus.cmd_sel;
               tmo_d   = 8'h0;
               state_d = BUS;
            end
         end
         BUS: begin
            // Ack takes priority over a timeout expiring on the same edge.
            if (bus.wbm_ack_i) begin
               rsp_dat_d = we_q ? 32'h0 : bus.wbm_dat_i;
               rsp_err_d = 1'b0;
               xfer_d    = xfer_q + 16'd1;
               state_d   = RESP;
            end else begin
               tmo_d = tmo_q + 8'd1;
               if (tmo_d == TIMEOUT_C) begin
                  rsp_dat_d = ERR_DATA;
                  rsp_err_d = 1'b1;
                  err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                  state_d   = RESP;
               end
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Decoded straight from the state so an asynchronous reset drops cyc/stb at once.
   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_dat   = rsp_dat_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.wbm_cyc_o = (state_q == BUS);
   assign bus.wbm_stb_o = (state_q == BUS);
   assign bus.wbm_we_o  = we_q;
   assign bus.wbm_sel_o = sel_q;
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_dat_o = dat_q;

   assign xfer_count = xfer_q;
   assign err_count  = err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed plus randomized bench for wb_cmd_master: a registered-ack slave with a
// programmable ack delay and a transaction-level reference model of responses and counters.
module tb_wb_cmd_master;
   localparam int          TMO = 16;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic        clk;
   logic        rst_n;
   logic [15:0] xfer_count;
   logic [7:0]  err_count;

   wb_cmd_master_if bus_if ();

   wb_cmd_master #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .bus       (bus_if),
      .xfer_count(xfer_count),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave: ack_at = number of stb-high cycles before the ack is sampled (0 = never).
   int          ack_at;
   int          scnt;
   logic        ack_r;
   logic        stale_ack;
   logic [31:0] rdat_r;
   logic [31:0] smem [0:15];

   assign bus_if.wbm_ack_i = ack_r | stale_ack;
   assign bus_if.wbm_dat_i = rdat_r;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scnt   <= 0;
         ack_r  <= 1'b0;
         rdat_r <= 32'h0;
      end else begin
         ack_r <= 1'b0;
         if (bus_if.wbm_stb_o && !ack_r) begin
            scnt <= scnt + 1;
            if (ack_at != 0 && scnt + 1 == ack_at - 1) begin
               ack_r  <= 1'b1;
               rdat_r <= smem[bus_if.wbm_adr_o[5:2]];
               if (bus_if.wbm_we_o) begin
                  for (int b = 0; b < 4; b++)
                     if (bus_if.wbm_sel_o[b])
                        smem[bus_if.wbm_adr_o[5:2]][8*b +: 8] <= bus_if.wbm_dat_o[8*b +: 8];
               end
            end
         end else begin
            scnt <= 0;
         end
      end
   end

   // Reference model state
   logic [31:0] mmem [int];
   logic [15:0] m_xfer;
   logic [7:0]  m_err;

   int checks;
   int errors;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ackat, input int hold, input bit stale);
      logic [31:0] exp_dat;
      bit          exp_err;
      int          exp_stb;
      int          stbc;
      int          cyc;
      int          k;
      logic [31:0] w;

      k       = int'(adr[5:2]);
      exp_err = (ackat == 0) || (ackat > TMO);
      exp_stb = exp_err ? TMO : ackat;
      if (exp_err) begin
         exp_dat = ERR;
         if (m_err != 8'd255) m_err = m_err + 8'd1;
      end else begin
         w = mmem.exists(k) ? mmem[k] : 32'h0;
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
            mmem[k] = w;
            exp_dat = 32'h0;
         end else begin
            exp_dat = w;
         end
         m_xfer = m_xfer + 16'd1;
      end

      ack_at            = ackat;
      bus_if.cmd_we     = we;
      bus_if.cmd_adr    = adr;
      bus_if.cmd_dat    = dat;
      bus_if.cmd_sel    = sel;
      bus_if.cmd_valid  = 1'b1;
      check("cmd_ready_idle", {31'h0, bus_if.cmd_ready}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      bus_if.cmd_valid = 1'b0;
      check("bus_adr", bus_if.wbm_adr_o, adr);
      check("bus_dat", bus_if.wbm_dat_o, dat);
      check("bus_sel_we", {27'h0, bus_if.wbm_sel_o, bus_if.wbm_we_o}, {27'h0, sel, we});
      check("bus_cyc", {31'h0, bus_if.wbm_cyc_o}, 32'h1);

      stbc = 0;
      cyc  = 0;
      while (!bus_if.rsp_valid && cyc < 400) begin
         if (bus_if.wbm_stb_o) stbc++;
         @(negedge clk);
         cyc++;
      end
      check("rsp_seen", {31'h0, bus_if.rsp_valid}, 32'h1);
      check("stb_cycles", stbc, exp_stb);
      check("rsp_dat", bus_if.rsp_dat, exp_dat);
      check("rsp_err", {31'h0, bus_if.rsp_err}, {31'h0, exp_err});
      check("xfer_count", {16'h0, xfer_count}, {16'h0, m_xfer});
      check("err_count", {24'h0, err_count}, {24'h0, m_err});

      for (int i = 0; i < hold; i++) begin
         stale_ack = stale;
         @(negedge clk);
         check("bp_valid", {31'h0, bus_if.rsp_valid}, 32'h1);
         check("bp_dat", bus_if.rsp_dat, exp_dat);
         check("bp_stb_ready", {30'h0, bus_if.wbm_stb_o, bus_if.cmd_ready}, 32'h0);
      end
      stale_ack = 1'b0;
      if (hold > 0) begin
         check("bp_xfer", {16'h0, xfer_count}, {16'h0, m_xfer});
         check("bp_err", {24'h0, err_count}, {24'h0, m_err});
      end

      bus_if.rsp_ready = 1'b1;
      @(negedge clk);
      bus_if.rsp_ready = 1'b0;
      check("back_idle", {30'h0, bus_if.cmd_ready, bus_if.rsp_valid}, 32'h2);
      check("adr_retained", bus_if.wbm_adr_o, adr);
      $display("txn we=%0d adr=%h dat=%h sel=%h ack_at=%0d rsp_dat=%h rsp_err=%0d stb=%0d xfer=%0d errc=%0d",
               we, adr, dat, sel, ackat, bus_if.rsp_dat, bus_if.rsp_err, stbc, xfer_count, err_count);
   endtask

   initial begin
      int r;
      checks = 0;
      errors = 0;
      m_xfer = 16'h0;
      m_err  = 8'h0;
      for (int i = 0; i < 16; i++) smem[i] = 32'h0;
      rst_n            = 1'b0;
      ack_at           = 0;
      stale_ack        = 1'b0;
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_we    = 1'b0;
      bus_if.cmd_adr   = 32'h0;
      bus_if.cmd_dat   = 32'h0;
      bus_if.cmd_sel   = 4'h0;
      bus_if.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_ready_valid", {30'h0, bus_if.cmd_ready, bus_if.rsp_valid}, 32'h2);
      check("rst_cyc_stb_we", {29'h0, bus_if.wbm_cyc_o, bus_if.wbm_stb_o, bus_if.wbm_we_o}, 32'h0);
      check("rst_adr", bus_if.wbm_adr_o, 32'h0);
      check("rst_dat_o", bus_if.wbm_dat_o, 32'h0);
      check("rst_sel_err", {27'h0, bus_if.wbm_sel_o, bus_if.rsp_err}, 32'h0);
      check("rst_rsp_dat", bus_if.rsp_dat, 32'h0);
      check("rst_counters", {8'h0, xfer_count, err_count}, 32'h0);

      // Project-select write then read-back, two-cycle ack
      do_cmd(1'b1, 32'h3000_0000, 32'h0000_0005, 4'hF, 2, 0, 1'b0);
      do_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 2, 0, 1'b0);
      check("ps_readback_lsb", {24'h0, bus_if.rsp_dat[7:0]}, 32'h05);
      check("ps_xfer_two", {16'h0, xfer_count}, 32'd2);

      // Unmapped address times out
      do_cmd(1'b0, 32'h3000_0300, 32'h0, 4'hF, 0, 0, 1'b0);
      // Ack on the final timeout cycle wins
      do_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, TMO, 0, 1'b0);
      // Response back-pressure with a stale ack in the window
      do_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3, 10, 1'b1);
      // Slave acking one cycle too late leaves a stale ack after a timeout
      do_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF, TMO + 1, 2, 1'b0);

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, TMO);
         do_cmd(1'($urandom_range(0, 1)), 32'h3000_0000 | (32'($urandom_range(0, 15)) << 2),
                $urandom, 4'($urandom_range(0, 15)), (r == 1) ? 0 : r,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a bus transfer
      ack_at           = 0;
      bus_if.cmd_we    = 1'b0;
      bus_if.cmd_adr   = 32'h3000_0008;
      bus_if.cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_stb_high", {30'h0, bus_if.wbm_cyc_o, bus_if.wbm_stb_o}, 32'h3);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_stb_drop", {30'h0, bus_if.wbm_cyc_o, bus_if.wbm_stb_o}, 32'h0);
      m_xfer = 16'h0;
      m_err  = 8'h0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_state", {30'h0, bus_if.cmd_ready, bus_if.rsp_valid}, 32'h2);
      check("post_rst_counters", {8'h0, xfer_count, err_count}, 32'h0);
      check("post_rst_adr", bus_if.wbm_adr_o, 32'h0);

      // Error counter saturation
      for (int n = 0; n < 260; n++)
         do_cmd(1'b0, 32'h3000_0300, 32'h0, 4'hF, 0, 0, 1'b0);
      check("err_saturated", {24'h0, err_count}, 32'd255);
      check("xfer_after_sat", {16'h0, xfer_count}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
